// File: rtl/escape_pkg.sv
// Shared types and sizing helpers for the escape_a unit arbiter.
package escape_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int unsigned CNT_W = 4;

  // Index width for n entries; never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/escape_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping modulo NREQ.
module escape_rr_pick
  import escape_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);

  int unsigned j;

  always_comb begin
    found = 1'b0;
    idx   = ptr;
    j     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && eligible[IW'(j)]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/escape_unit_arb.sv
// Round-robin arbiter/sequencer sharing one escape_a unit between NREQ requesters,
// one transaction in flight, outputs captured after a fixed unit latency.
module escape_unit_arb
  import escape_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt,
  output logic            unit_i,
  output logic            unit_vld,
  input  logic            unit_o10,
  input  logic            unit_o2,
  output logic [NREQ-1:0] rsp_vld,
  output logic            rsp_o10,
  output logic            rsp_o2,
  output logic            busy
);

  localparam int unsigned    IW   = idx_w(NREQ);
  localparam logic [IW-1:0]  LAST = IW'(NREQ - 1);

  state_t             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cap;
  logic [IW-1:0]      id_nxt;
  logic [IW-1:0]      pick_ptr;
  logic [NREQ-1:0]    eligible;
  logic               pick_found;
  logic [IW-1:0]      pick_idx;

  // The requester just answered loses first priority in RESP and is masked out.
  assign id_nxt   = (id_q == LAST) ? '0 : id_q + IW'(1);
  assign pick_ptr = (state_q == RESP) ? id_nxt : ptr_q;
  assign eligible = req & ~rsp_vld;

  escape_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .eligible (eligible),
    .ptr      (pick_ptr),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          id_d    = pick_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          cap     = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        ptr_d = id_nxt;
        if (pick_found) begin
          id_d    = pick_idx;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= '0;
      unit_vld <= 1'b0;
      unit_i   <= 1'b0;
      rsp_vld  <= '0;
      busy     <= 1'b0;
      rsp_o10  <= 1'b0;
      rsp_o2   <= 1'b0;
    end else begin
      gnt      <= (state_d == ISSUE) ? (NREQ'(1) << id_d) : '0;
      unit_vld <= (state_d == ISSUE);
      unit_i   <= (state_d == ISSUE) && req_i[id_d];
      rsp_vld  <= (state_d == RESP) ? (NREQ'(1) << id_d) : '0;
      busy     <= (state_d != IDLE);
      if (cap) begin
        rsp_o10 <= unit_o10;
        rsp_o2  <= unit_o2;
      end
    end
  end

endmodule

// File: tb/tb_escape_unit_arb.sv
// Directed bench for escape_unit_arb: four builds (4/2, 3/2, 4/1, 4/15) each driving a behavioural unit.
module tb_escape_unit_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  logic [3:0] req_a     [4];
  logic [3:0] req_i_a   [4];
  logic [3:0] gnt_a     [4];
  logic [3:0] rsp_vld_a [4];
  logic       unit_vld_a[4];
  logic       unit_i_a  [4];
  logic       busy_a    [4];
  logic       ro10_a    [4];
  logic       ro2_a     [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned NR = (g == 1) ? 3 : 4;
    localparam int unsigned LT = (g == 2) ? 1 : (g == 3) ? 15 : 2;
    logic [NR-1:0] gnt_l, rsp_vld_l;
    logic          unit_vld_l, unit_i_l, o10_l, o2_l, busy_l, ro10_l, ro2_l;
    logic [15:0]   vpipe = '0;
    logic          cur_i = 1'b0;

    escape_unit_arb #(.NREQ(NR), .LAT(LT)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req_a[g][NR-1:0]),
      .req_i    (req_i_a[g][NR-1:0]),
      .gnt      (gnt_l),
      .unit_i   (unit_i_l),
      .unit_vld (unit_vld_l),
      .unit_o10 (o10_l),
      .unit_o2  (o2_l),
      .rsp_vld  (rsp_vld_l),
      .rsp_o10  (ro10_l),
      .rsp_o2   (ro2_l),
      .busy     (busy_l)
    );

    // Unit: o10 = i, o2 = ~i, valid only LT cycles after the strobe; inverted garbage otherwise.
    always @(posedge clk) begin
      vpipe <= {vpipe[14:0], unit_vld_l};
      if (unit_vld_l) cur_i <= unit_i_l;
    end
    assign o10_l = vpipe[LT-1] ? cur_i : ~cur_i;
    assign o2_l  = vpipe[LT-1] ? ~cur_i : cur_i;

    assign gnt_a[g]      = 4'(gnt_l);
    assign rsp_vld_a[g]  = 4'(rsp_vld_l);
    assign unit_vld_a[g] = unit_vld_l;
    assign unit_i_a[g]   = unit_i_l;
    assign busy_a[g]     = busy_l;
    assign ro10_a[g]     = ro10_l;
    assign ro2_a[g]      = ro2_l;
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic test_reset;
    logic [14:0] obs;
    rst = 1'b1;
    for (int g = 0; g < 4; g++) begin
      req_a[g]   = '0;
      req_i_a[g] = '0;
    end
    repeat (3) tick();
    for (int g = 0; g < 4; g++) begin
      obs = {gnt_a[g], rsp_vld_a[g], unit_vld_a[g], unit_i_a[g], busy_a[g], ro10_a[g], ro2_a[g]};
      checks++;
      if (obs !== 15'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %b expected %b", g, obs, 15'd0);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    req_i_a[0] = 4'b0100;
    req_a[0]   = 4'b0100;
    tick();
    checks++; if (gnt_a[0] !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b expected 0100", gnt_a[0]); end
    checks++; if (unit_vld_a[0] !== 1'b1) begin errors++; $display("FAIL single_unit_vld: got %b expected 1", unit_vld_a[0]); end
    checks++; if (unit_i_a[0] !== 1'b1) begin errors++; $display("FAIL single_unit_i: got %b expected 1", unit_i_a[0]); end
    checks++; if (busy_a[0] !== 1'b1) begin errors++; $display("FAIL single_busy_c1: got %b expected 1", busy_a[0]); end
    tick();
    checks++; if ({busy_a[0], gnt_a[0]} !== 5'b1_0000) begin errors++; $display("FAIL single_c2: got busy/gnt %b expected 10000", {busy_a[0], gnt_a[0]}); end
    tick();
    checks++; if ({busy_a[0], rsp_vld_a[0]} !== 5'b1_0000) begin errors++; $display("FAIL single_c3: got busy/rsp_vld %b expected 10000", {busy_a[0], rsp_vld_a[0]}); end
    tick();
    checks++; if (rsp_vld_a[0] !== 4'b0100) begin errors++; $display("FAIL single_rsp_vld: got %b expected 0100", rsp_vld_a[0]); end
    checks++; if ({ro10_a[0], ro2_a[0]} !== 2'b10) begin errors++; $display("FAIL single_rsp_data: got %b expected 10", {ro10_a[0], ro2_a[0]}); end
    checks++; if (busy_a[0] !== 1'b1) begin errors++; $display("FAIL single_busy_c4: got %b expected 1", busy_a[0]); end
    req_a[0] = '0;
    tick();
    checks++; if ({busy_a[0], rsp_vld_a[0], ro10_a[0], ro2_a[0]} !== 7'b0_0000_10) begin
      errors++; $display("FAIL single_after: got busy/rsp_vld/o10/o2 %b expected 0000010", {busy_a[0], rsp_vld_a[0], ro10_a[0], ro2_a[0]});
    end
  endtask

  task automatic test_round_robin;
    int         gid [5];
    int         gcyc[5];
    int         n = 0;
    int         id;
    logic [3:0] raise = '0;
    rst = 1'b1; tick(); rst = 1'b0;
    req_i_a[0] = 4'b1010;
    req_a[0]   = 4'b1111;
    for (int c = 0; c < 60 && n < 5; c++) begin
      tick();
      if (gnt_a[0] != 4'b0000) begin
        gid[n]  = oh_idx(gnt_a[0]);
        gcyc[n] = cyc;
        n++;
      end
      if (rsp_vld_a[0] != 4'b0000) begin
        id = oh_idx(rsp_vld_a[0]);
        checks++;
        if ({ro10_a[0], ro2_a[0]} !== {req_i_a[0][id], ~req_i_a[0][id]}) begin
          errors++; $display("FAIL rr_rsp_data[%0d]: got %b expected %b", id, {ro10_a[0], ro2_a[0]}, {req_i_a[0][id], ~req_i_a[0][id]});
        end
      end
      req_a[0] = req_a[0] | raise;
      raise    = rsp_vld_a[0];
      req_a[0] = req_a[0] & ~rsp_vld_a[0];
    end
    req_a[0] = '0;
    checks++;
    if (n != 5) begin errors++; $display("FAIL rr_grant_count: got %0d expected 5", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (gid[i] != i % 4) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, gid[i], i % 4); end
      if (i > 0) begin
        checks++;
        if (gcyc[i] - gcyc[i-1] != 4) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d expected 4", i, gcyc[i] - gcyc[i-1]); end
      end
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_vld_a[0] != 4'b0000) break;
    end
    tick();
  endtask

  task automatic test_wrap;
    rst = 1'b1; tick(); rst = 1'b0;
    req_i_a[1] = 4'b0010;
    req_a[1]   = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_vld_a[1] != 4'b0000) break;
    end
    checks++; if (rsp_vld_a[1] !== 4'b0010) begin errors++; $display("FAIL wrap_first_rsp: got %b expected 0010", rsp_vld_a[1]); end
    req_a[1] = '0;
    tick();
    req_a[1] = 4'b0011;
    tick();
    checks++; if (gnt_a[1] !== 4'b0001) begin errors++; $display("FAIL wrap_gnt: got %b expected 0001", gnt_a[1]); end
    req_a[1] = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_vld_a[1] != 4'b0000) break;
    end
    checks++; if ({rsp_vld_a[1], ro10_a[1], ro2_a[1]} !== 6'b0001_01) begin
      errors++; $display("FAIL wrap_rsp: got rsp_vld/o10/o2 %b expected 000101", {rsp_vld_a[1], ro10_a[1], ro2_a[1]});
    end
    tick();
  endtask

  task automatic test_latency(input int g, input int lat);
    int   t0;
    logic v;
    for (int k = 0; k < 2; k++) begin
      v          = (k == 0);
      req_i_a[g] = {3'b000, v};
      req_a[g]   = 4'b0001;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (gnt_a[g] != 4'b0000) break;
      end
      checks++; if (gnt_a[g] !== 4'b0001) begin errors++; $display("FAIL lat%0d_gnt: got %b expected 0001", lat, gnt_a[g]); end
      t0       = cyc;
      req_a[g] = '0;
      for (int c = 0; c < 40; c++) begin
        tick();
        if (rsp_vld_a[g] != 4'b0000) break;
      end
      checks++; if (rsp_vld_a[g] !== 4'b0001) begin errors++; $display("FAIL lat%0d_rsp_vld: got %b expected 0001", lat, rsp_vld_a[g]); end
      checks++; if (cyc - t0 != lat + 1) begin errors++; $display("FAIL lat%0d_distance: got %0d expected %0d", lat, cyc - t0, lat + 1); end
      checks++; if ({ro10_a[g], ro2_a[g]} !== {v, ~v}) begin errors++; $display("FAIL lat%0d_data: got %b expected %b", lat, {ro10_a[g], ro2_a[g]}, {v, ~v}); end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    logic [14:0] obs;
    int          seen = 0;
    req_i_a[0] = 4'b0100;
    req_a[0]   = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (gnt_a[0] != 4'b0000) break;
    end
    checks++; if (gnt_a[0] !== 4'b0100) begin errors++; $display("FAIL abort_gnt: got %b expected 0100", gnt_a[0]); end
    req_a[0] = '0;
    tick();
    rst = 1'b1;
    tick();
    obs = {gnt_a[0], rsp_vld_a[0], unit_vld_a[0], unit_i_a[0], busy_a[0], ro10_a[0], ro2_a[0]};
    checks++; if (obs !== 15'd0) begin errors++; $display("FAIL abort_outputs: got %b expected %b", obs, 15'd0); end
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (rsp_vld_a[0] != 4'b0000 || busy_a[0]) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_rsp: got %0d active cycles expected 0", seen); end
    req_a[0] = 4'b1001;
    tick();
    checks++; if (gnt_a[0] !== 4'b0001) begin errors++; $display("FAIL abort_fresh_gnt: got %b expected 0001", gnt_a[0]); end
    req_a[0] = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_vld_a[0] != 4'b0000) break;
    end
    tick();
  endtask

  task automatic test_hold;
    req_i_a[0] = 4'b0010;
    req_a[0]   = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_vld_a[0] != 4'b0000) break;
    end
    checks++; if (rsp_vld_a[0] !== 4'b0010) begin errors++; $display("FAIL hold_rsp: got %b expected 0010", rsp_vld_a[0]); end
    tick();
    checks++; if ({busy_a[0], gnt_a[0]} !== 5'b0_0000) begin errors++; $display("FAIL hold_no_regrant: got busy/gnt %b expected 00000", {busy_a[0], gnt_a[0]}); end
    tick();
    checks++; if (gnt_a[0] !== 4'b0010) begin errors++; $display("FAIL hold_regrant: got %b expected 0010", gnt_a[0]); end
    req_a[0] = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_vld_a[0] != 4'b0000) break;
    end
    repeat (2) tick();
  endtask

  initial begin
    for (int g = 0; g < 4; g++) begin
      req_a[g]   = '0;
      req_i_a[g] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_latency(2, 1);
    test_latency(3, 15);
    test_reset_mid();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
